// File: rtl/vp_issue_sequencer.sv
// vp_issue_sequencer: instruction front end for the 16x32 vector datapath.
// Buffers instructions in a small FIFO, then walks each one through its
// timed phases while driving the memory / register-file / ALU control strobes.
module vp_issue_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1,
  parameter int MEM_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_opcode,
  input  logic [1:0]  in_rf_addr,
  input  logic [4:0]  in_mem_addr,
  output logic [1:0]  opcode,
  output logic [1:0]  rf_address,
  output logic [4:0]  mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic        rf_read,
  output logic        rf_write,
  output logic        read_two_regs,
  output logic        write_two_regs,
  output logic        alu_in_load,
  output logic        rf_in_load,
  output logic        busy,
  output logic        done,
  output logic [15:0] retired_count
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int MAXLAT = (ALU_LAT > MEM_LAT) ? ALU_LAT : MEM_LAT;
  localparam int CW     = $clog2(MAXLAT) + 1;
  // Counter reload values; the ALU phase is in its first cycle while the
  // counter still holds its reload value.
  localparam logic [CW-1:0] C_ALU_INIT = CW'(ALU_LAT - 1);
  localparam logic [CW-1:0] C_MEM_INIT = CW'(MEM_LAT - 1);

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_MUL   = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;
  localparam logic [1:0] OP_STORE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_RD2, S_ALU, S_WB, S_MRD, S_RFW, S_RRD, S_MWR
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;

  // FIFO: entry = {opcode, rf index, memory index}; pointers carry a wrap bit
  logic [8:0]      r_fifo [FIFO_DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [8:0]      w_head;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;

  logic [1:0]      r_opcode;
  logic [1:0]      r_rf_address;
  logic [4:0]      r_mem_address;
  logic [15:0]     r_retired_count;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_fifo[r_rd_ptr[AW-1:0]];

  assign in_ready      = !w_full;
  assign busy          = (r_state != S_IDLE) || !w_empty;
  assign opcode        = r_opcode;
  assign rf_address    = r_rf_address;
  assign mem_address   = r_mem_address;
  assign retired_count = r_retired_count;

  // FIFO storage write; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[AW-1:0]] <= {in_opcode, in_rf_addr, in_mem_addr};
    end
  end

  // Next-state, wait counter, pop decision and phase strobes
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_pop          = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    rf_read        = 1'b0;
    rf_write       = 1'b0;
    read_two_regs  = 1'b0;
    write_two_regs = 1'b0;
    alu_in_load    = 1'b0;
    rf_in_load     = 1'b0;
    done           = 1'b0;

    case (r_state)
      S_RD2: begin
        read_two_regs = 1'b1;
        w_state_next  = S_ALU;
        w_cnt_next    = C_ALU_INIT;
      end
      S_ALU: begin
        alu_in_load = (r_cnt == C_ALU_INIT);
        if (r_cnt == '0) begin
          w_state_next = S_WB;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_WB: begin
        rf_in_load     = 1'b1;
        write_two_regs = 1'b1;
        done           = 1'b1;
      end
      S_MRD: begin
        mem_read = 1'b1;
        if (r_cnt == '0) begin
          w_state_next = S_RFW;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_RFW: begin
        mem_read = 1'b1;
        rf_write = 1'b1;
        done     = 1'b1;
      end
      S_RRD: begin
        rf_read      = 1'b1;
        w_state_next = S_MWR;
      end
      S_MWR: begin
        rf_read   = 1'b1;
        mem_write = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase

    // Issue point: idle or last phase of the current instruction (no bubble)
    if ((r_state == S_IDLE) || done) begin
      if (!w_empty) begin
        w_pop = 1'b1;
        case (w_head[8:7])
          OP_ADD, OP_MUL: w_state_next = S_RD2;
          OP_LOAD: begin
            w_state_next = S_MRD;
            w_cnt_next   = C_MEM_INIT;
          end
          OP_STORE: w_state_next = S_RRD;
          default: w_state_next = S_IDLE;
        endcase
      end else begin
        w_state_next = S_IDLE;
      end
    end
  end

  // State, counter, FIFO pointers, issued-instruction fields and retire count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_opcode        <= '0;
      r_rf_address    <= '0;
      r_mem_address   <= '0;
      r_retired_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr      <= r_rd_ptr + 1'b1;
        r_opcode      <= w_head[8:7];
        r_rf_address  <= w_head[6:5];
        r_mem_address <= w_head[4:0];
      end
      if (done) begin
        r_retired_count <= r_retired_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/vp_issue_sequencer.md
Name: vp_issue_sequencer

Overview:
- Front-end controller for the vector processor datapath: 512-bit vectors (16x32), 4-entry register file, 32-entry main memory.
- Accepts instructions over a valid/ready handshake and buffers them in a small FIFO.
- Sequences each instruction through timed phases, driving the datapath's memory, register-file, ALU-latch and write-back control strobes.
- Replaces free-running per-opcode control with an explicit FSM, a busy indication and a retired-instruction count.

Parameters:
- FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2.
- ALU_LAT, 1, cycles the ALU result needs after operands are latched; >= 1.
- MEM_LAT, 1, cycles main memory needs after mem_read before data is valid; >= 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  FIFO can accept; equals !full.
- in_opcode  in  2  0=ADD, 1=MUL, 2=LOAD, 3=STORE.
- in_rf_addr  in  2  register index, used by LOAD/STORE.
- in_mem_addr  in  5  memory word index, used by LOAD/STORE.
- opcode  out  2  opcode of the executing instruction.
- rf_address  out  2  rf index of the executing instruction.
- mem_address  out  5  memory index of the executing instruction.
- mem_read, mem_write  out  1 each  memory strobes.
- rf_read, rf_write  out  1 each  single-register strobes.
- read_two_regs, write_two_regs  out  1 each  dual-register strobes (arith: reads R0/R1, writes R2/R3).
- alu_in_load  out  1  datapath latches rf_out_1/rf_out_2 into the ALU inputs this edge.
- rf_in_load  out  1  datapath latches alu_out_1/alu_out_2 into rf_in_1/rf_in_2 this edge.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- done  out  1  high during the final phase cycle of each instruction.
- retired_count  out  16  instructions completed; wraps at 2^16.

Behaviour:
- Reset (async, any time, including mid-instruction): FIFO flushed; FSM to IDLE. Every output 0 except in_ready=1: all strobes, opcode, rf_address, mem_address, busy, done and retired_count.
- FIFO: push when in_valid && in_ready. No bypass: a pushed entry is poppable from the next edge. When full, in_ready=0 even if a pop occurs in the same cycle. Push and pop may coincide when not full; occupancy is then unchanged.
- Pop: in IDLE, or in any instruction's final phase, when the FIFO is non-empty. The popped entry loads into opcode/rf_address/mem_address and the FSM enters that instruction's first phase. Back-to-back instructions have no bubble.
- Address outputs hold their value until the next pop.
- ADD/MUL phases:
  - RD2, 1 cycle: read_two_regs=1.
  - ALU, ALU_LAT cycles: alu_in_load=1 in the first cycle only.
  - WB, 1 cycle: rf_in_load=1 and write_two_regs=1; done=1.
- LOAD phases:
  - MRD, MEM_LAT cycles: mem_read=1.
  - RFW, 1 cycle: mem_read=1 and rf_write=1; done=1.
- STORE phases:
  - RRD, 1 cycle: rf_read=1.
  - MWR, 1 cycle: rf_read=1 and mem_write=1; done=1.
- Instruction length: ADD/MUL = 2+ALU_LAT cycles; LOAD = 1+MEM_LAT; STORE = 2.
- Wait counter: one internal counter, loaded on phase entry and counting down to 0. Width is clog2(max(ALU_LAT, MEM_LAT))+1.
- Strobes are combinational from FSM state and counter, glitch-free relative to clk. Invariants: never mem_read&&mem_write; never rf_write&&write_two_regs.
- retired_count increments on the edge ending each done=1 cycle.
- Final phase with the FIFO empty: FSM returns to IDLE and all strobes go to 0.
- Instructions retire strictly in FIFO order. There is no hazard checking: program order through the single sequencer is sufficient.

Test Plan:
- Reset mid-ADD (assert rst during the ALU phase) -> all strobes 0 immediately, in_ready=1, retired_count=0. After release the FIFO is empty and busy=0.
- Single ADD pushed at edge E0 (defaults) -> read_two_regs in E1-E2; alu_in_load in E2-E3; write_two_regs, rf_in_load and done in E3-E4; retired_count=1 after E4; busy=0 after E4.
- LOAD rf=2, mem=17, then STORE rf=2, mem=17, pushed on consecutive edges -> mem_read with mem_address=17 for 2 cycles, rf_write in the 2nd. Next cycle rf_read, then rf_read+mem_write; no idle gap; retired_count=2.
- Push 6 instructions back-to-back with FIFO_DEPTH=4 while one ADD is executing -> in_ready drops after 4 are buffered. It rises the cycle after the first pop; all 6 retire in order (check opcode sequence).
- ALU_LAT=3, MEM_LAT=4 build, MUL then LOAD -> MUL spans 5 cycles with alu_in_load only in its 2nd cycle; LOAD asserts mem_read for 5 cycles with rf_write only in the last.
- Preload retired_count near wrap (run 65535 STOREs, or force) then one more STORE -> retired_count wraps to 0 with no other side effect.
